exec_issue: RTL

EXEC_ISSUE -- requirements
Module: exec_issue

---
 rtl/exec_pkg.sv | 52 +++++
 rtl/exec_decode.sv | 28 ++
 rtl/exec_issue.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the execute-issue block: instruction layout, class and
// sub-op codes, datapath widths and the issue FSM state type.
package exec_pkg;

    localparam int INSTR_W  = 32;
    localparam int REG_W    = 32;
    localparam int RADDR_W  = 5;
    localparam int SUBOP_W  = 3;
    localparam int IMM_W    = 16;
    localparam int SHAMT_W  = 5;

    typedef enum logic [2:0] {
        SHIFT_REG   = 3'b000,
        ARITH_LOGIC = 3'b001,
        MEM_READ    = 3'b100,
        MEM_WRITE   = 3'b101
    } class_e;

    typedef enum logic [2:0] {
        SH_SLL = 3'd0,
        SH_SRL = 3'd1,
        SH_SRA = 3'd2,
        SH_ROL = 3'd3
    } shift_op_e;

    typedef enum logic [2:0] {
        AR_ADD  = 3'd0,
        AR_SUB  = 3'd1,
        AR_AND  = 3'd2,
        AR_OR   = 3'd3,
        AR_XOR  = 3'd4,
        AR_SLT  = 3'd5,
        AR_SLTU = 3'd6,
        AR_LUI  = 3'd7
    } arith_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        ISSUE = 2'd2,
        WB    = 2'd3
    } state_e;

    typedef struct packed {
        logic [2:0]         cls;
        logic [SUBOP_W-1:0] subop;
        logic [RADDR_W-1:0] dest;
        logic [RADDR_W-1:0] src1;
        logic [IMM_W-1:0]   imm;
    } instr_t;

endpackage

// File: rtl/exec_decode.sv
// Combinational class/sub-op decode: selects the shift unit, the arithmetic
// unit, or flags the instruction as unsupported. Exactly one output is high.
module exec_decode
    import exec_pkg::*;
(
    input  logic [2:0]         class_i,
    input  logic [SUBOP_W-1:0] subop_i,
    output logic               shift_sel_o,
    output logic               arith_sel_o,
    output logic               illegal_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        shift_sel_o = 1'b0;
        arith_sel_o = 1'b0;
        illegal_o   = 1'b0;
        case (class_i)
            SHIFT_REG: begin
                if (subop_i[2]) illegal_o   = 1'b1;  // only sub-ops 0..3 are shifts
                else            shift_sel_o = 1'b1;
            end
            ARITH_LOGIC: arith_sel_o = 1'b1;
            default:     illegal_o   = 1'b1;
        endcase
    end

endmodule

// File: rtl/exec_issue.sv
// Execute-issue FSM: accepts one instruction, reads its source register,
// drives the selected ALU for one cycle and reports the writeback a cycle later.
module exec_issue
    import exec_pkg::*;
#(
    parameter int INSTR_WIDTH    = 32,
    parameter int REGISTER_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [INSTR_WIDTH-1:0]    instr,
    output logic [RADDR_W-1:0]        rf_raddr,
    input  logic [REGISTER_WIDTH-1:0] rf_rdata,
    output logic                      shift_enable,
    output logic [SUBOP_W-1:0]        shift_operation,
    output logic [SHAMT_W-1:0]        shift_amt,
    output logic [REGISTER_WIDTH-1:0] shift_in,
    output logic                      arith_enable,
    output logic [SUBOP_W-1:0]        arith_operation,
    output logic [REGISTER_WIDTH-1:0] arith_a,
    output logic [IMM_W-1:0]          arith_imm,
    output logic                      wb_valid,
    output logic [RADDR_W-1:0]        wb_dest,
    output logic                      illegal
);

    instr_t instr_w;
    assign instr_w = instr;

    state_e                    state_q;
    logic                      ready_q;
    logic [2:0]                cls_q;
    logic [SUBOP_W-1:0]        subop_q;
    logic [RADDR_W-1:0]        dest_q;
    logic [IMM_W-1:0]          imm_q;
    logic [REGISTER_WIDTH-1:0] operand_q;
    logic [RADDR_W-1:0]        raddr_q;
    logic                      shift_en_q, arith_en_q, illegal_q, wb_valid_q;
    logic [SUBOP_W-1:0]        shift_op_q, arith_op_q;
    logic [SHAMT_W-1:0]        shift_amt_q;
    logic [REGISTER_WIDTH-1:0] shift_in_q, arith_a_q;
    logic [IMM_W-1:0]          arith_imm_q;
    logic [RADDR_W-1:0]        wb_dest_q;

    logic shift_sel, arith_sel, illegal_sel;

    exec_decode u_decode (
        .class_i     (cls_q),
        .subop_i     (subop_q),
        .shift_sel_o (shift_sel),
        .arith_sel_o (arith_sel),
        .illegal_o   (illegal_sel)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the latched instruction fields are reset too, so an abandoned op leaves no stale state.
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            cls_q       <= '0;
            subop_q     <= '0;
            dest_q      <= '0;
            imm_q       <= '0;
            operand_q   <= '0;
            raddr_q     <= '0;
            shift_en_q  <= 1'b0;
            arith_en_q  <= 1'b0;
            illegal_q   <= 1'b0;
            wb_valid_q  <= 1'b0;
            shift_op_q  <= '0;
            arith_op_q  <= '0;
            shift_amt_q <= '0;
            shift_in_q  <= '0;
            arith_a_q   <= '0;
            arith_imm_q <= '0;
            wb_dest_q   <= '0;
        end else begin
            // NOTE: non-blocking throughout; pulses default low and are raised only in their state.
            shift_en_q <= 1'b0;
            arith_en_q <= 1'b0;
            illegal_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (instr_valid && ready_q) begin
                        cls_q   <= instr_w.cls;
                        subop_q <= instr_w.subop;
                        dest_q  <= instr_w.dest;
                        imm_q   <= instr_w.imm;
                        raddr_q <= instr_w.src1;
                        ready_q <= 1'b0;
                        state_q <= READ;
                    end
                end
                READ: begin
                    operand_q <= rf_rdata;
                    state_q   <= ISSUE;
                end
                ISSUE: begin
                    if (shift_sel) begin
                        shift_en_q  <= 1'b1;
                        shift_op_q  <= subop_q;
                        shift_amt_q <= imm_q[SHAMT_W-1:0];
                        shift_in_q  <= operand_q;
                        state_q     <= WB;
                    end else if (arith_sel) begin
                        arith_en_q  <= 1'b1;
                        arith_op_q  <= subop_q;
                        arith_a_q   <= operand_q;
                        arith_imm_q <= imm_q;
                        state_q     <= WB;
                    end else begin
                        illegal_q <= illegal_sel;
                        ready_q   <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                WB: begin
                    wb_valid_q <= 1'b1;
                    wb_dest_q  <= dest_q;
                    ready_q    <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign instr_ready     = ready_q;
    assign rf_raddr        = raddr_q;
    assign shift_enable    = shift_en_q;
    assign shift_operation = shift_op_q;
    assign shift_amt       = shift_amt_q;
    assign shift_in        = shift_in_q;
    assign arith_enable    = arith_en_q;
    assign arith_operation = arith_op_q;
    assign arith_a         = arith_a_q;
    assign arith_imm       = arith_imm_q;
    assign wb_valid        = wb_valid_q;
    assign wb_dest         = wb_dest_q;
    assign illegal         = illegal_q;

endmodule
